// File: rtl/wb_pipe.sv
// wb_pipe: MEM/WB back end of the integer pipeline.
// Registers EX results through MEM and WB, runs the load handshake with the
// data memory, drives the register-file write port and publishes the MEM/WB
// contents as forwarding sources.
// Optional feature: define WB_FWD_EN to build the WB-stage forward outputs;
// otherwise fwd_wb_* are tied to 0 and the register file must write through.
module wb_pipe #(
  parameter int DST_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DST_W-1:0]  ex_dst,
  input  logic              ex_wb_ctrl,
  input  logic              ex_is_load,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              fwd_mem_valid,
  output logic [DST_W-1:0]  fwd_mem_dst,
  output logic [DATA_W-1:0] fwd_mem_data,
  output logic              fwd_mem_pending,
  output logic              fwd_wb_valid,
  output logic [DST_W-1:0]  fwd_wb_dst,
  output logic [DATA_W-1:0] fwd_wb_data,
  output logic              rf_we,
  output logic [DST_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } load_state_t;

  load_state_t state, state_next;

  // MEM stage contents
  logic              mem_valid;
  logic [DATA_W-1:0] mem_result;
  logic [DST_W-1:0]  mem_dst;
  logic              mem_wb_ctrl;
  logic              mem_is_load;

  // WB stage contents
  logic              wb_we;
  logic [DST_W-1:0]  wb_dst;
  logic [DATA_W-1:0] wb_data;

  logic load_busy;
  logic capture;
  logic mem_we;
  logic advance;

  // A load is outstanding in REQ or WAIT; ready in that cycle releases the
  // front end at once so a zero-wait load costs no bubble.
  assign load_busy = (state != S_IDLE);
  assign stall     = load_busy && !mem_ready;
  assign capture   = ex_valid && !stall;
  // Writes to r0 are architecturally discarded.
  assign mem_we    = mem_wb_ctrl && (mem_dst != '0);
  // A MEM entry moves to WB whenever the pipe is not frozen; for a load this
  // is exactly the mem_ready cycle.
  assign advance   = mem_valid && !stall;

  // Load FSM state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Load FSM next-state and memory request outputs
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next = state;
    mem_req    = 1'b0;
    mem_addr   = '0;
    case (state)
      S_IDLE: begin
        if (capture && ex_is_load) state_next = S_REQ;
      end
      S_REQ, S_WAIT: begin
        mem_req  = (state == S_REQ);
        mem_addr = mem_result;
        if (mem_ready) state_next = (capture && ex_is_load) ? S_REQ : S_IDLE;
        else           state_next = S_WAIT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // MEM stage: capture EX unless frozen by an outstanding load
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset as well because every output,
    // including the forward data buses, must read 0 out of reset.
    if (rst) begin
      mem_valid   <= 1'b0;
      mem_result  <= '0;
      mem_dst     <= '0;
      mem_wb_ctrl <= 1'b0;
      mem_is_load <= 1'b0;
    end else if (!stall) begin
      mem_valid <= ex_valid;
      if (ex_valid) begin
        mem_result  <= ex_result;
        mem_dst     <= ex_dst;
        mem_wb_ctrl <= ex_wb_ctrl;
        mem_is_load <= ex_is_load;
      end
    end
  end

  // WB stage: one register-file write per cycle, bubble while frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_dst  <= '0;
      wb_data <= '0;
    end else begin
      wb_we <= advance && mem_we;
      if (advance) begin
        wb_dst  <= mem_dst;
        wb_data <= mem_is_load ? mem_rdata : mem_result;
      end
    end
  end

  assign fwd_mem_valid   = mem_valid && !mem_is_load && mem_we;
  assign fwd_mem_pending = mem_valid &&  mem_is_load && mem_we;
  assign fwd_mem_dst     = mem_dst;
  assign fwd_mem_data    = mem_result;

  assign rf_we    = wb_we;
  assign rf_waddr = wb_dst;
  assign rf_wdata = wb_data;

`ifdef WB_FWD_EN
  assign fwd_wb_valid = wb_we;
  assign fwd_wb_dst   = wb_dst;
  assign fwd_wb_data  = wb_data;
`else
  assign fwd_wb_valid = 1'b0;
  assign fwd_wb_dst   = '0;
  assign fwd_wb_data  = '0;
`endif

endmodule

// File: tb/tb_wb_pipe.sv
// Self-checking bench for wb_pipe: directed scenarios plus randomized
// instruction streams with a memory responder of random latency. Expected
// register-file writes and load requests are queued at issue time and
// consumed by independent monitor processes.
module tb_wb_pipe;
  localparam int DST_W  = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_result;
  logic [DST_W-1:0]  ex_dst;
  logic              ex_wb_ctrl;
  logic              ex_is_load;
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall;
  logic              fwd_mem_valid;
  logic [DST_W-1:0]  fwd_mem_dst;
  logic [DATA_W-1:0] fwd_mem_data;
  logic              fwd_mem_pending;
  logic              fwd_wb_valid;
  logic [DST_W-1:0]  fwd_wb_dst;
  logic [DATA_W-1:0] fwd_wb_data;
  logic              rf_we;
  logic [DST_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  wb_pipe #(.DST_W(DST_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_dst(ex_dst),
    .ex_wb_ctrl(ex_wb_ctrl), .ex_is_load(ex_is_load),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .stall(stall),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_dst(fwd_mem_dst),
    .fwd_mem_data(fwd_mem_data), .fwd_mem_pending(fwd_mem_pending),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_dst(fwd_wb_dst),
    .fwd_wb_data(fwd_wb_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DST_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    logic [DATA_W-1:0] addr;
    int                lat;
    logic [DATA_W-1:0] rdata;
  } ld_t;

  wr_t exp_q[$];
  ld_t ld_q[$];
  int  total = 0;
  int  bad   = 0;
  int  stall_cycles = 0;
  int  lat_sum = 0;
  bit  spurious = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Present one EX instruction (called at posedge+2), hold it through any
  // stall, and queue what the design must eventually do with it.
  task automatic issue(input logic v, input logic [DATA_W-1:0] res,
                       input logic [DST_W-1:0] dst, input logic wbc,
                       input logic ld, input int lat,
                       input logic [DATA_W-1:0] rdata);
    int guard = 0;
    ex_valid   = v;
    ex_result  = res;
    ex_dst     = dst;
    ex_wb_ctrl = wbc;
    ex_is_load = ld;
    while (stall && guard < 100) begin
      @(posedge clk); #2;
      guard++;
    end
    if (guard >= 100) fail_now("issue_stall_timeout");
    if (v && ld) begin
      ld_q.push_back('{addr: res, lat: lat, rdata: rdata});
      lat_sum += lat;
    end
    if (v && wbc && dst != 0) exp_q.push_back('{dst: dst, data: (ld ? rdata : res)});
    @(posedge clk); #2;
    ex_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #2;
  endtask

  task automatic wait_no_stall(input string name);
    int n = 0;
    while (stall && n < 50) begin
      next_cycle();
      n++;
    end
    if (n >= 50) fail_now(name);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},  mem_req, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_stall"},    stall, 0);
    check({tag, "_fmv"},      fwd_mem_valid, 0);
    check({tag, "_fmd"},      fwd_mem_dst, 0);
    check({tag, "_fmdata"},   fwd_mem_data, 0);
    check({tag, "_fmp"},      fwd_mem_pending, 0);
    check({tag, "_fwv"},      fwd_wb_valid, 0);
    check({tag, "_fwd"},      fwd_wb_dst, 0);
    check({tag, "_fwdata"},   fwd_wb_data, 0);
    check({tag, "_rf_we"},    rf_we, 0);
    check({tag, "_rf_waddr"}, rf_waddr, 0);
    check({tag, "_rf_wdata"}, rf_wdata, 0);
  endtask

  // Memory responder: serves each requested load after its chosen latency.
  initial begin
    int  cnt = 0;
    bit  waiting = 1'b0;
    ld_t cur;
    mem_ready = 1'b0;
    mem_rdata = '0;
    cur = '{addr: '0, lat: 0, rdata: '0};
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        waiting   = 1'b0;
        mem_ready = 1'b0;
        continue;
      end
      mem_ready = spurious;
      if (spurious) mem_rdata = 32'h5A5A_5A5A;
      if (waiting) begin
        cnt--;
        check("mem_addr_held", mem_addr, cur.addr);
        check("mem_req_in_wait", mem_req, 0);
        if (cnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = cur.rdata;
          waiting   = 1'b0;
        end
      end
      if (mem_req) begin
        if (ld_q.size() == 0) begin
          fail_now("unexpected_mem_req");
        end else begin
          cur = ld_q.pop_front();
          check("mem_addr_req", mem_addr, cur.addr);
          if (cur.lat == 0) begin
            mem_ready = 1'b1;
            mem_rdata = cur.rdata;
          end else begin
            waiting = 1'b1;
            cnt     = cur.lat;
          end
        end
      end
    end
  end

  // Write-port monitor: every rf_we must match the next queued write.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall) stall_cycles++;
      if (rf_we) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_rf_write");
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          check("rf_waddr", rf_waddr, w.dst);
          check("rf_wdata", rf_wdata, w.data);
`ifdef WB_FWD_EN
          check("fwd_wb_valid", fwd_wb_valid, 1);
          check("fwd_wb_dst", fwd_wb_dst, w.dst);
          check("fwd_wb_data", fwd_wb_data, w.data);
`endif
        end
      end
`ifdef WB_FWD_EN
      else check("fwd_wb_valid_idle", fwd_wb_valid, 0);
`else
      check("fwd_wb_valid_off", fwd_wb_valid, 0);
      check("fwd_wb_dst_off", fwd_wb_dst, 0);
      check("fwd_wb_data_off", fwd_wb_data, 0);
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst        = 1'b1;
    ex_valid   = 1'b0;
    ex_result  = '0;
    ex_dst     = '0;
    ex_wb_ctrl = 1'b0;
    ex_is_load = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst = 1'b0;
    next_cycle();

    // ALU result forwarded from MEM, then written from WB
    issue(1, 32'h0000_00AA, 5'd3, 1, 0, 0, '0);
    check("alu_fwd_valid", fwd_mem_valid, 1);
    check("alu_fwd_dst", fwd_mem_dst, 3);
    check("alu_fwd_data", fwd_mem_data, 32'hAA);
    check("alu_pending", fwd_mem_pending, 0);
    check("alu_stall_n1", stall, 0);
    next_cycle();
    check("alu_rf_we", rf_we, 1);
    check("alu_rf_waddr", rf_waddr, 3);
    check("alu_rf_wdata", rf_wdata, 32'hAA);
    check("alu_stall_n2", stall, 0);
    next_cycle();

    // Zero-wait load
    issue(1, 32'h100, 5'd5, 1, 1, 0, 32'hDEAD_BEEF);
    check("zw_mem_req", mem_req, 1);
    check("zw_mem_addr", mem_addr, 32'h100);
    check("zw_stall", stall, 0);
    next_cycle();
    check("zw_rf_we", rf_we, 1);
    check("zw_rf_waddr", rf_waddr, 5);
    check("zw_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
    next_cycle();

    // Three-cycle wait-state load
    issue(1, 32'h100, 5'd5, 1, 1, 3, 32'h1234_5678);
    n = 0;
    while (stall && n < 20) begin
      check("ws_mem_addr", mem_addr, 32'h100);
      check("ws_pending", fwd_mem_pending, 1);
      check("ws_fwd_valid", fwd_mem_valid, 0);
      next_cycle();
      n++;
    end
    check("ws_stall_len", n, 3);
    next_cycle();
    check("ws_rf_we", rf_we, 1);
    check("ws_rf_wdata", rf_wdata, 32'h1234_5678);
    next_cycle();

    // Register 0: neither ALU nor load may write or forward
    issue(1, 32'h55, 5'd0, 1, 0, 0, '0);
    check("r0_fwd_valid", fwd_mem_valid, 0);
    check("r0_pending", fwd_mem_pending, 0);
    next_cycle();
    check("r0_rf_we", rf_we, 0);
    issue(1, 32'h40, 5'd0, 1, 1, 2, 32'h7777_7777);
    check("r0ld_pending", fwd_mem_pending, 0);
    check("r0ld_fwd_valid", fwd_mem_valid, 0);
    wait_no_stall("r0ld_stall_timeout");
    next_cycle();
    check("r0ld_rf_we", rf_we, 0);
    next_cycle();

    // Reset while a load waits, then a stray ready
    issue(1, 32'h200, 5'd7, 1, 1, 5, 32'hCAFE_F00D);
    next_cycle();
    check("rml_wait_req", mem_req, 0);
    check("rml_wait_stall", stall, 1);
    rst = 1'b1;
    exp_q.delete();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    ld_q.delete();
    spurious = 1'b1;
    next_cycle();
    check("rml_ready_seen", mem_ready, 1);
    check("rml_stall", stall, 0);
    check("rml_mem_req", mem_req, 0);
    spurious = 1'b0;
    next_cycle();
    check_all_zero("rml");
    next_cycle();
    check("rml_rf_we_late", rf_we, 0);

    // Randomized stream with back-to-back loads and random latency
    base    = stall_cycles;
    lat_sum = 0;
    repeat (300) begin
      issue(($urandom_range(0, 9) < 8), $urandom(), DST_W'($urandom_range(0, 31)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 4),
            $urandom_range(0, 4), $urandom());
    end
    n = 0;
    while ((exp_q.size() != 0 || stall) && n < 50) begin
      next_cycle();
      n++;
    end
    if (n >= 50) fail_now("drain_timeout");
    repeat (3) next_cycle();
    check("stall_total", stall_cycles - base, lat_sum);
    check("exp_q_empty", exp_q.size(), 0);
    check("ld_q_empty", ld_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
